// File: rtl/uart_pkg.sv
// Purpose : shared UART receive-path helpers: sampling-window arithmetic and SAMPLES legality.
// Latency : n/a (package, combinational functions only).
// Backpr. : n/a.
//
// The RX FSM calls win_first/win_decide to align edge_cnt with the oversampler's window.
// Results are plain unsigned ints; callers truncate to PRESC_W+1 bits, so a Prescale
// too small for the window wraps to a large index, exactly as the hardware compare sees it.
package uart_pkg;

   // SAMPLES must be odd so the majority vote can never tie, and small enough for the counters.
   function automatic bit samples_legal(input int unsigned samples);
      return ((samples % 2) == 1) && (samples <= 7);
   endfunction

   // First edge_cnt index sampled: the window is centred on the bit middle.
   function automatic int unsigned win_first(input int unsigned prescale,
                                             input int unsigned samples);
      return (prescale / 2) - (samples / 2);
   endfunction

   // edge_cnt index on which the vote is taken (one past the last sample).
   function automatic int unsigned win_decide(input int unsigned prescale,
                                              input int unsigned samples);
      return win_first(prescale, samples) + samples;
   endfunction

endpackage

// File: rtl/uart_sync.sv
// Purpose : STAGES-deep flop chain that brings an asynchronous input into the CLK domain.
// Latency : STAGES cycles (STAGES=0 is a straight wire).
// Backpr. : none; free-running.
//
// Ports:
//   CLK     clock
//   RST     synchronous active-low reset; every flop resets to 1 (idle line level)
//   async_i asynchronous input
//   sync_o  synchronised output
module uart_sync #(
   parameter int STAGES = 2
) (
   input  logic CLK,
   input  logic RST,
   input  logic async_i,
   output logic sync_o
);

   if (STAGES == 0) begin : g_bypass
      assign sync_o = async_i;
   end else begin : g_chain
      logic [STAGES-1:0] chain_q;

      always_ff @(posedge CLK) begin
         if (!RST) begin
            chain_q <= '1;
         end else begin
            chain_q[0] <= async_i;
            for (int i = 1; i < STAGES; i++) begin
               chain_q[i] <= chain_q[i-1];
            end
         end
      end

      assign sync_o = chain_q[STAGES-1];
   end

endmodule

// File: rtl/uart_rx_oversampler.sv
// Purpose : mid-bit majority-vote sampler between the RX pin and the RX FSM.
// Latency : decision registered on the edge after edge_cnt==DECIDE; +SYNC_STAGES from the pin.
// Backpr. : none; bit_valid is a single-cycle strobe the consumer must take on that cycle.
//
// Ports:
//   CLK, RST     oversampling clock, synchronous active-low reset
//   RX_IN        asynchronous serial input
//   samp_en      sampling enable from the RX FSM
//   edge_cnt     oversample index within the current bit, 0..Prescale-1
//   Prescale     oversampling ratio (quasi-static)
//   sampled_bit  voted bit, holds between decisions
//   bit_valid    one-cycle pulse when sampled_bit is updated
//   noise_err    samples disagreed or the window was incomplete (updated at each decision point)
//   cfg_err      Prescale cannot hold the sampling window
module uart_rx_oversampler
   import uart_pkg::*;
#(
   parameter int SAMPLES     = 3,
   parameter int PRESC_W     = 6,
   parameter int SYNC_STAGES = 2
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               RX_IN,
   input  logic               samp_en,
   input  logic [PRESC_W-1:0] edge_cnt,
   input  logic [PRESC_W-1:0] Prescale,
   output logic               sampled_bit,
   output logic               bit_valid,
   output logic               noise_err,
   output logic               cfg_err
);

   localparam int WIN_W = PRESC_W + 1;
   localparam int CNT_W = $clog2(SAMPLES + 1);
   localparam logic [CNT_W-1:0] SAMP_C = CNT_W'(SAMPLES);
   localparam logic [CNT_W-1:0] HALF_C = CNT_W'(SAMPLES / 2);
   localparam logic [WIN_W-1:0] HALF_W = WIN_W'(SAMPLES / 2);

   if (!samples_legal(SAMPLES)) begin : g_samples_illegal
      $fatal(1, "uart_rx_oversampler: SAMPLES must be odd and within 1..7");
   end

   // ---------------------------------------------------------------------------
   // Input synchroniser
   // ---------------------------------------------------------------------------
   logic rx_s;

   uart_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .CLK     (CLK),
      .RST     (RST),
      .async_i (RX_IN),
      .sync_o  (rx_s)
   );

   // ---------------------------------------------------------------------------
   // Window arithmetic, one bit wider than Prescale so an undersized Prescale
   // wraps FIRST to a value edge_cnt can never reach.
   // ---------------------------------------------------------------------------
   logic [WIN_W-1:0] presc_w;
   logic [WIN_W-1:0] edge_w;
   logic [WIN_W-1:0] first_w;
   logic [WIN_W-1:0] decide_w;
   logic             cfg_err_d;
   logic             at_first;
   logic             in_window;
   logic             at_decide;

   assign presc_w  = {1'b0, Prescale};
   assign edge_w   = {1'b0, edge_cnt};
   assign first_w  = WIN_W'(win_first(32'(Prescale), SAMPLES));
   assign decide_w = WIN_W'(win_decide(32'(Prescale), SAMPLES));

   assign cfg_err_d = ((presc_w >> 1) < HALF_W) || (decide_w > (presc_w - WIN_W'(1)));

   assign at_first  = (edge_w == first_w);
   assign in_window = (edge_w > first_w) && (edge_w < decide_w);
   assign at_decide = (edge_w == decide_w);

   // ---------------------------------------------------------------------------
   // Accumulator and decision
   // ---------------------------------------------------------------------------
   logic [CNT_W-1:0] ones_q, ones_d;
   logic [CNT_W-1:0] got_q, got_d;
   logic             sampled_bit_q, sampled_bit_d;
   logic             bit_valid_q, bit_valid_d;
   logic             noise_err_q, noise_err_d;
   logic             cfg_err_q;

   always_comb begin
      ones_d        = ones_q;
      got_d         = got_q;
      sampled_bit_d = sampled_bit_q;
      noise_err_d   = noise_err_q;
      bit_valid_d   = 1'b0;

      if (!samp_en || cfg_err_q) begin
         ones_d = '0;
         got_d  = '0;
      end else if (at_first) begin
         // Loading (not adding) realigns the window and drops anything left over.
         ones_d = CNT_W'(rx_s);
         got_d  = CNT_W'(1);
      end else if (in_window) begin
         ones_d = ones_q + CNT_W'(rx_s);
         got_d  = got_q + CNT_W'(1);
      end else if (at_decide) begin
         if (got_q == SAMP_C) begin
            sampled_bit_d = (ones_q > HALF_C);
            noise_err_d   = (ones_q != '0) && (ones_q != SAMP_C);
            bit_valid_d   = 1'b1;
         end else begin
            // An index was skipped: the vote is untrustworthy, keep the old bit.
            noise_err_d = 1'b1;
         end
         ones_d = '0;
         got_d  = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         ones_q        <= '0;
         got_q         <= '0;
         sampled_bit_q <= 1'b1;
         bit_valid_q   <= 1'b0;
         noise_err_q   <= 1'b0;
         cfg_err_q     <= 1'b0;
      end else begin
         ones_q        <= ones_d;
         got_q         <= got_d;
         sampled_bit_q <= sampled_bit_d;
         bit_valid_q   <= bit_valid_d;
         noise_err_q   <= noise_err_d;
         cfg_err_q     <= cfg_err_d;
      end
   end

   assign sampled_bit = sampled_bit_q;
   assign bit_valid   = bit_valid_q;
   assign noise_err   = noise_err_q;
   assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Purpose : self-checking bench for uart_rx_oversampler, SAMPLES=3 and SAMPLES=5 side by side.
// Latency : n/a.
// Backpr. : n/a.
module tb_uart_rx_oversampler;

   localparam int MAXC = 16384;
   localparam int SAMP [2] = '{3, 5};

   logic            CLK = 1'b0;
   logic            RST;
   logic [1:0]      rx_in;
   logic [1:0]      samp_en;
   logic [1:0][5:0] edge_cnt;
   logic [1:0][5:0] presc;
   logic [1:0]      sbit, bvld, nerr, cerr;

   always #5 CLK = ~CLK;

   uart_rx_oversampler #(.SAMPLES(3), .PRESC_W(6), .SYNC_STAGES(2)) u_dut3 (
      .CLK(CLK), .RST(RST), .RX_IN(rx_in[0]), .samp_en(samp_en[0]),
      .edge_cnt(edge_cnt[0]), .Prescale(presc[0]),
      .sampled_bit(sbit[0]), .bit_valid(bvld[0]), .noise_err(nerr[0]), .cfg_err(cerr[0])
   );

   uart_rx_oversampler #(.SAMPLES(5), .PRESC_W(6), .SYNC_STAGES(2)) u_dut5 (
      .CLK(CLK), .RST(RST), .RX_IN(rx_in[1]), .samp_en(samp_en[1]),
      .edge_cnt(edge_cnt[1]), .Prescale(presc[1]),
      .sampled_bit(sbit[1]), .bit_valid(bvld[1]), .noise_err(nerr[1]), .cfg_err(cerr[1])
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: the pin history is kept per cycle; rx_s is simply the pin
   // two cycles back (or idle-high shortly after reset). Each window collects a
   // list of sampled values and votes on it when the decision index arrives.
   // ---------------------------------------------------------------------------
   bit hist [2][MAXC];
   int cyc     = 0;
   int rst_cyc = 0;
   int m_bit [2], m_vld [2], m_noise [2], m_cfg [2];
   int nsamp [2];
   int smp   [2][8];

   function automatic void model_step();
      int p, s, e, rxs, first, decide, ones, new_cfg;
      cyc++;
      if (!RST) rst_cyc = cyc;
      for (int k = 0; k < 2; k++) begin
         hist[k][cyc] = rx_in[k];
         if (!RST) begin
            m_bit[k] = 1; m_vld[k] = 0; m_noise[k] = 0; m_cfg[k] = 0; nsamp[k] = 0;
         end else begin
            rxs     = (cyc - 2 > rst_cyc) ? int'(hist[k][cyc-2]) : 1;
            p       = int'(presc[k]);
            s       = SAMP[k];
            e       = int'(edge_cnt[k]);
            first   = ((p / 2) - (s / 2)) & 127;
            decide  = (first + s) & 127;
            new_cfg = ((p / 2) < (s / 2)) || (decide > ((p - 1) & 127));
            m_vld[k] = 0;
            if (!samp_en[k] || m_cfg[k] != 0) begin
               nsamp[k] = 0;
            end else if (e == first) begin
               smp[k][0] = rxs;
               nsamp[k]  = 1;
            end else if (e > first && e < decide) begin
               if (nsamp[k] < 8) smp[k][nsamp[k]] = rxs;
               nsamp[k]++;
            end else if (e == decide) begin
               if (nsamp[k] == s) begin
                  ones = 0;
                  for (int j = 0; j < s; j++) ones += smp[k][j];
                  m_bit[k]   = (ones > s / 2) ? 1 : 0;
                  m_noise[k] = (ones != 0 && ones != s) ? 1 : 0;
                  m_vld[k]   = 1;
               end else begin
                  m_noise[k] = 1;
               end
               nsamp[k] = 0;
            end
            m_cfg[k] = new_cfg;
         end
      end
   endfunction

   // One clock: inputs are already set, model steps at the edge, outputs compared mid-cycle.
   task automatic tick();
      @(posedge CLK);
      model_step();
      @(negedge CLK);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("s%0d.sampled_bit", SAMP[k]), int'(sbit[k]), m_bit[k]);
         check($sformatf("s%0d.bit_valid", SAMP[k]),   int'(bvld[k]), m_vld[k]);
         check($sformatf("s%0d.noise_err", SAMP[k]),   int'(nerr[k]), m_noise[k]);
         check($sformatf("s%0d.cfg_err", SAMP[k]),     int'(cerr[k]), m_cfg[k]);
      end
   endtask

   int win_pulses;
   int win_pidx;

   // Drives one bit period on instance k. pat[i] is the wanted rx_s at edge index i,
   // so the pin is driven two indices early to cover the synchroniser delay.
   task automatic run_window(input int k, input int p, input logic [63:0] pat,
                             input int skip_i, input int drop_i, input int rst_i);
      win_pulses = 0;
      win_pidx   = -1;
      for (int i = 0; i < p; i++) begin
         if (i == skip_i) continue;
         edge_cnt[k]   = 6'(i);
         samp_en[k]    = (i != drop_i);
         RST           = (i != rst_i);
         rx_in[k]      = (i + 2 < 64) ? pat[i+2] : 1'b1;
         edge_cnt[1-k] = '0;
         samp_en[1-k]  = 1'b0;
         rx_in[1-k]    = 1'($urandom);
         tick();
         if (bvld[k]) begin
            win_pulses++;
            win_pidx = i;
         end
         if (i == rst_i) begin
            check("rst_mid.sampled_bit", int'(sbit[k]), 1);
            check("rst_mid.bit_valid",   int'(bvld[k]), 0);
            check("rst_mid.noise_err",   int'(nerr[k]), 0);
         end
      end
      samp_en[k] = 1'b0;
      RST        = 1'b1;
   endtask

   initial begin
      int k, p, sel, skip_i, drop_i, rst_i;
      logic [63:0] pat;

      RST = 1'b0; rx_in = '1; samp_en = '0; edge_cnt = '0;
      presc[0] = 6'd8; presc[1] = 6'd16;
      repeat (3) tick();
      check("reset.sampled_bit", int'(sbit[0]), 1);
      check("reset.bit_valid",   int'(bvld[0]), 0);
      check("reset.noise_err",   int'(nerr[0]), 0);
      check("reset.cfg_err",     int'(cerr[1]), 0);
      RST = 1'b1;
      repeat (2) tick();

      // S=3, P=8, line idle high: samples 3,4,5, pulse after index 6.
      run_window(0, 8, '1, -1, -1, -1);
      check("idle.pulses", win_pulses, 1);
      check("idle.pulse_idx", win_pidx, 6);
      check("idle.bit", int'(sbit[0]), 1);
      check("idle.noise", int'(nerr[0]), 0);

      // 1,0,1 -> majority 1 with noise; then a clean zero.
      run_window(0, 8, 64'h28, -1, -1, -1);
      check("101.bit", int'(sbit[0]), 1);
      check("101.noise", int'(nerr[0]), 1);
      run_window(0, 8, '0, -1, -1, -1);
      check("000.bit", int'(sbit[0]), 0);
      check("000.noise", int'(nerr[0]), 0);

      // S=5, P=16: 0,0,1,1,0 at 6..10 -> 0 with noise, decided at index 11.
      run_window(1, 16, 64'h300, -1, -1, -1);
      check("s5.pulses", win_pulses, 1);
      check("s5.pulse_idx", win_pidx, 11);
      check("s5.bit", int'(sbit[1]), 0);
      check("s5.noise", int'(nerr[1]), 1);

      // S=5 with P=4 cannot hold the window.
      presc[1] = 6'd4;
      tick();
      check("cfg.err_set", int'(cerr[1]), 1);
      for (int w = 0; w < 3; w++) begin
         run_window(1, 4, '1, -1, -1, -1);
         check("cfg.no_pulse", win_pulses, 0);
      end
      presc[1] = 6'd16;
      tick();
      check("cfg.err_clr", int'(cerr[1]), 0);
      run_window(1, 16, '1, -1, -1, -1);
      check("cfg.resume_pulses", win_pulses, 1);
      check("cfg.resume_bit", int'(sbit[1]), 1);

      // Skipped index 4: no pulse, noise flagged, bit held at the previous 0.
      run_window(0, 8, '1, 4, -1, -1);
      check("skip.pulses", win_pulses, 0);
      check("skip.noise", int'(nerr[0]), 1);
      check("skip.bit", int'(sbit[0]), 0);

      // samp_en low at index 4, then a clean window.
      run_window(0, 8, '1, -1, 4, -1);
      check("drop.pulses", win_pulses, 0);
      run_window(0, 8, '1, -1, -1, -1);
      check("drop.next_pulses", win_pulses, 1);
      check("drop.next_bit", int'(sbit[0]), 1);
      check("drop.next_noise", int'(nerr[0]), 0);

      // Reset at index 4 after a zero bit, then a clean zero window.
      run_window(0, 8, '0, -1, -1, -1);
      run_window(0, 8, '0, -1, -1, 4);
      check("rst.pulses", win_pulses, 0);
      run_window(0, 8, '0, -1, -1, -1);
      check("rst.next_pulses", win_pulses, 1);
      check("rst.next_bit", int'(sbit[0]), 0);
      check("rst.next_noise", int'(nerr[0]), 0);

      // Randomised windows, checked cycle by cycle against the model.
      for (int w = 0; w < 250; w++) begin
         k = $urandom_range(0, 1);
         p = $urandom_range(4, 40);
         presc[k] = 6'(p);
         tick();
         tick();
         sel = $urandom_range(0, 2);
         if (sel == 0)      pat = '0;
         else if (sel == 1) pat = '1;
         else               pat = {$urandom, $urandom};
         skip_i = ($urandom_range(0, 7) == 0) ? $urandom_range(0, p - 1) : -1;
         drop_i = ($urandom_range(0, 7) == 0) ? $urandom_range(0, p - 1) : -1;
         rst_i  = ($urandom_range(0, 15) == 0) ? $urandom_range(0, p - 1) : -1;
         run_window(k, p, pat, skip_i, drop_i, rst_i);
         check("rand.pulses_le1", (win_pulses <= 1) ? 1 : 0, 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_oversampler.md
# uart_rx_oversampler

Parametrised mid-bit sampler for the UART receive path. It sits between the RX pin and the RX FSM/deserializer and consumes the edge counter already used by the receiver. It synchronises RX_IN and takes SAMPLES consecutive oversamples centred on the bit middle. It outputs the majority-voted bit with a one-cycle valid strobe, a noise flag when the samples disagree, and a configuration error flag when Prescale is too small for the sampling window.

## Interface
- SAMPLES, 3: samples per bit; odd, legal values 1, 3, 5, 7.
- PRESC_W, 6: width of Prescale and edge_cnt.
- SYNC_STAGES, 2: synchroniser flops on RX_IN; 0 means no synchroniser.
- CLK  in  1  oversampling clock.
- RST  in  1  reset, synchronous, active-low.
- RX_IN  in  1  serial input, asynchronous.
- samp_en  in  1  sampling enable from the RX FSM.
- edge_cnt  in  PRESC_W  oversample index within the current bit, 0..Prescale-1.
- Prescale  in  PRESC_W  oversampling ratio, quasi-static.
- sampled_bit  out  1  voted bit value; holds between decisions.
- bit_valid  out  1  one-cycle pulse when sampled_bit is updated.
- noise_err  out  1  registered with bit_valid; samples not unanimous, or window incomplete.
- cfg_err  out  1  level; Prescale cannot hold the window.

## Operation
- rx_s is RX_IN delayed by SYNC_STAGES flops. The flops reset to 1 (idle line). The RX FSM compensates for this delay in edge_cnt alignment.
- Window indices (integer division, computed at PRESC_W+1 bits unsigned):
  - FIRST = Prescale/2 - SAMPLES/2.
  - Samples are taken at edge_cnt = FIRST .. FIRST+SAMPLES-1.
  - DECIDE = FIRST+SAMPLES.
- cfg_err = (Prescale/2 < SAMPLES/2) or (DECIDE > Prescale-1). It is registered every cycle regardless of samp_en. While cfg_err=1, no samples are taken and bit_valid stays 0.
- Accumulator state:
  - ones_cnt, width $clog2(SAMPLES+1): count of 1-samples.
  - got_cnt, same width: count of samples taken.
- Sampling, with samp_en=1 and cfg_err=0:
  - At edge_cnt==FIRST: ones_cnt loads rx_s and got_cnt loads 1. This realigns the window and discards stale state.
  - At edge_cnt in FIRST+1..FIRST+SAMPLES-1: ones_cnt += rx_s and got_cnt += 1.
- Decision at edge_cnt==DECIDE:
  - If got_cnt==SAMPLES:
    - sampled_bit <= (ones_cnt > SAMPLES/2).
    - noise_err <= (ones_cnt!=0 && ones_cnt!=SAMPLES).
    - bit_valid <= 1.
  - Otherwise (edge_cnt skipped an index): sampled_bit holds, noise_err <= 1, bit_valid <= 0.
  - In both cases ones_cnt and got_cnt clear to 0.
- SAMPLES=1: FIRST=Prescale/2, single sample, noise_err is never 1 for a complete window.
- samp_en=0: ones_cnt and got_cnt clear, bit_valid=0, and sampled_bit and noise_err hold. The synchroniser keeps running.
- Reset mid-window clears all state. The next window starting at FIRST is sampled normally.

## Timing
- Reset values:
  - sampled_bit = 1, bit_valid = 0, noise_err = 0, cfg_err = 0.
  - ones_cnt = 0, got_cnt = 0, sync flops = 1.
- Latency: bit_valid, sampled_bit and noise_err update on the clock edge following the cycle with edge_cnt==DECIDE. Latency from the RX_IN pin is SYNC_STAGES cycles more.
- bit_valid is exactly 1 cycle wide and occurs at most once per bit period. There is no back-pressure; the consumer captures it on that cycle.
- cfg_err follows a Prescale change after 1 cycle. A Prescale change mid-window gives undefined data for that bit only.
- samp_en dropping on the DECIDE cycle suppresses the decision.

## Structure
- Shared package uart_pkg holds:
  - SAMPLES legal-value check (elaboration assertion: odd, 1..7).
  - Function win_first(prescale, samples).
  - Function win_decide(prescale, samples).
  - The RX FSM reuses both functions for alignment.
- One sub-module: uart_sync. It is a SYNC_STAGES-deep flop chain with reset value 1 and is reused for other asynchronous inputs.

## Test plan
- SAMPLES=3, Prescale=8, samp_en=1, rx=1 held, edge_cnt 0..7 -> samples at 3,4,5; bit_valid pulse on the edge after edge_cnt=6; sampled_bit=1, noise_err=0.
- Same config, rx_s=1,0,1 at indices 3,4,5 -> sampled_bit=1, noise_err=1; the next clean all-0 bit -> sampled_bit=0, noise_err=0.
- SAMPLES=5, Prescale=16, rx_s=0,0,1,1,0 at indices 6..10 -> decision after index 11: sampled_bit=0, noise_err=1, bit_valid for 1 cycle.
- SAMPLES=5, Prescale=4 -> cfg_err=1 one cycle later; no bit_valid over 3 bit periods. Prescale=16 -> cfg_err=0 and normal decisions resume.
- SAMPLES=3, Prescale=8, edge_cnt jumps 3->5 (index 4 skipped) -> at DECIDE: bit_valid=0, noise_err=1, sampled_bit unchanged.
- Disturbances, SAMPLES=3, Prescale=8:
  - samp_en low at edge_cnt=4 -> no bit_valid.
  - RST low at edge_cnt=4 -> sampled_bit=1, bit_valid=0, noise_err=0.
  - In both cases the following full window decodes correctly.
